rvx_rr_grant_arbiter: RTL
=========================

Name: rvx_rr_grant_arbiter

Overview:
- Registered round-robin arbiter for N requesters sharing one resource, e.g. a bus port or a DMA channel.
- Built around a combinational first-set one-hot selector; this block adds the rotating priority mask, the grant hold and release handshake, and a hold-timeout watchdog.
- Sits directly downstream of request collection logic and upstream of the shared-resource mux, which consumes grant and grant_idx.

Parameters:
- NUM_REQ, 4, number of requesters (>=1).
- IDX_W, $clog2(NUM_REQ) (min 1), width of grant_idx.
- MAX_HOLD, 0, maximum cycles a grant may be held before forced revoke; 0 disables the timeout.
- CNT_W, 16, width of the hold counter; MAX_HOLD must be < 2**CNT_W.

Ports:
- clk  input  1  system clock, rising edge.
- rstnn  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  request vector, level-sensitive.
- release_req  input  1  current owner finishes; sampled only in GRANTED.
- grant  output  NUM_REQ  registered one-hot grant.
- grant_valid  output  1  high while any grant is held.
- grant_idx  output  IDX_W  binary index of the grant bit; 0 when no grant.
- timeout  output  1  one-cycle pulse on forced revoke.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rstnn), all state cleared immediately on assertion.
  - State=IDLE; grant=0, grant_valid=0, grant_idx=0, timeout=0.
  - Priority pointer last_idx=NUM_REQ-1, so requester 0 has top priority after reset.
  - hold_cnt=0.
- States: IDLE, GRANTED.
- IDLE to GRANTED, when req!=0 at a rising edge:
  - masked = req & thermometer mask of bits strictly above last_idx.
  - sel = first_set(masked) if masked!=0, else first_set(req). first_set means lowest index wins.
  - Registered on that edge: grant=sel, grant_valid=1, grant_idx=encode(sel), hold_cnt=0.
  - Latency: req to grant is 1 cycle.
- IDLE with req==0: stay; outputs remain 0.
- GRANTED:
  - grant is frozen. req changes, including deassertion by the owner, are ignored.
  - hold_cnt increments each cycle and saturates at its maximum.
- GRANTED to IDLE on release_req=1:
  - Next edge: grant=0, grant_valid=0, grant_idx=0, last_idx=granted index.
- GRANTED to IDLE on timeout (MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, release_req=0):
  - Same clearing as release, and timeout=1 for exactly that following cycle.
  - last_idx is updated, so the offender loses priority.
- Simultaneous release_req and timeout condition: treat as release; timeout stays 0.
- Mandatory bubble: at least one IDLE cycle between consecutive grants. Back-to-back grants are not supported, so minimum grant period is 2 cycles plus the hold time.
- Wrap-around:
  - last_idx=NUM_REQ-1 gives masked=0, so the full req vector is searched from bit 0.
  - A single active requester always wins regardless of pointer.
- NUM_REQ=1: mask logic degenerates; the requester is granted whenever req=1. grant_idx is 1 bit and always 0.
- release_req in IDLE is ignored.
- Reset mid-grant: outputs drop asynchronously, the pointer returns to NUM_REQ-1, and no timeout pulse is issued.
- Invariants, checked by bench assertions:
  - grant is one-hot or zero.
  - grant_valid == |grant.
  - grant_idx matches grant.

Decomposition:
- Shared package holds:
  - the state encoding constants RR_ST_IDLE and RR_ST_GRANTED;
  - a function for thermometer-mask generation, (index to mask of bits above it);
  - a function for one-hot-to-binary encode.
- One sub-module is natural: rvx_first_one_select.
  - Parameterised width, combinational, outputs the lowest set bit as one-hot.
  - Instantiated twice, once for masked and once for raw req.

Test Plan:
- Reset then req=4'b1010 -> after 1 edge grant=4'b0010, grant_idx=1, grant_valid=1; release_req pulse -> next cycle grant=0.
- req held at 4'b1111 with release_req one cycle after each grant -> grant sequence 0001, 0010, 0100, 1000, 0001, with one IDLE cycle between grants.
- Last grant index 3, then req=4'b1001 -> grant 0001 (wrap-around); then with last=0, req=4'b1001 -> grant 1000.
- MAX_HOLD=5, grant to req 2, release_req never asserted -> grant drops 5 cycles after assertion; timeout high for exactly 1 cycle; with req=4'b0101 held, next grant goes to req 0.
- Owner drops req during grant, no release_req -> grant held unchanged; release_req at the same cycle as the timeout condition -> timeout stays 0.
- rstnn asserted mid-grant, asynchronously between edges -> grant, grant_valid and grant_idx are 0 before the next edge; after release, req=4'b1111 -> grant 0001.

Source files
------------

// File: rtl/rvx_rr_grant_arbiter_pkg.sv
// Shared definitions for the round-robin grant arbiter: state encoding and
// the mask/encode helpers used to build the rotating priority.
package rvx_rr_grant_arbiter_pkg;

    // Helpers work on a fixed wide vector; callers cast down to NUM_REQ bits.
    localparam int RR_MAX_REQ = 64;

    typedef enum logic {
        RR_ST_IDLE    = 1'b0,
        RR_ST_GRANTED = 1'b1
    } rr_state_e;

    // Thermometer mask with every bit strictly above idx set.
    function automatic logic [RR_MAX_REQ-1:0] rr_mask_above(input int idx);
        logic [RR_MAX_REQ-1:0] m;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            m[i] = (i > idx);
        end
        return m;
    endfunction

    // One-hot to binary; a zero vector encodes to 0.
    function automatic int rr_onehot_to_idx(input logic [RR_MAX_REQ-1:0] vec);
        int r;
        r = 0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            if (vec[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/rvx_first_one_select.sv
// Combinational first-set selector: keeps only the lowest set bit of vec.
module rvx_first_one_select #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic [WIDTH-1:0] onehot
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = vec & (~vec + WIDTH'(1));

endmodule

// File: rtl/rvx_rr_grant_arbiter.sv
// Registered round-robin arbiter with grant hold, release handshake and an
// optional hold-timeout watchdog that forcibly revokes a stuck owner.
module rvx_rr_grant_arbiter
    import rvx_rr_grant_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int MAX_HOLD = 0,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rstnn,
    input  logic [NUM_REQ-1:0] req,
    input  logic               release_req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_RESET = IDX_W'(NUM_REQ - 1);

    rr_state_e          state;
    logic [IDX_W-1:0]   last_idx;
    logic [CNT_W-1:0]   hold_cnt;

    logic [NUM_REQ-1:0] above_mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] sel_masked;
    logic [NUM_REQ-1:0] sel_raw;
    logic [NUM_REQ-1:0] sel;
    logic [IDX_W-1:0]   sel_idx;
    logic               hold_expired;

    assign above_mask = NUM_REQ'(rr_mask_above(int'(last_idx)));
    assign masked     = req & above_mask;

    rvx_first_one_select #(.WIDTH(NUM_REQ)) u_sel_masked (
        .vec    (masked),
        .onehot (sel_masked)
    );

    rvx_first_one_select #(.WIDTH(NUM_REQ)) u_sel_raw (
        .vec    (req),
        .onehot (sel_raw)
    );

    // Nothing above the pointer requesting means wrap and search from bit 0.
    assign sel     = (|masked) ? sel_masked : sel_raw;
    assign sel_idx = IDX_W'(rr_onehot_to_idx(RR_MAX_REQ'(sel)));

    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state       <= RR_ST_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            timeout     <= 1'b0;
            last_idx    <= IDX_RESET;
            hold_cnt    <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                RR_ST_IDLE: begin
                    if (|req) begin
                        state       <= RR_ST_GRANTED;
                        grant       <= sel;
                        grant_valid <= 1'b1;
                        grant_idx   <= sel_idx;
                        hold_cnt    <= '0;
                    end
                end
                RR_ST_GRANTED: begin
                    // Release wins over a coincident timeout, so no pulse then.
                    if (release_req || hold_expired) begin
                        state       <= RR_ST_IDLE;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_idx   <= '0;
                        last_idx    <= grant_idx;
                        timeout     <= !release_req;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= RR_ST_IDLE;
            endcase
        end
    end

endmodule
